// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command sequencer and register file behind the SPI byte receiver.
// A one-byte header selects write (bit7=1) or read (bit7=0) and a 4-bit start address;
// following bytes stream into the control registers or out of the control/status map.
// Frames end on frame_rst or after TIMEOUT quiet cycles.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   frame_rst  synchronous frame abort, returns to idle
//   rx_byte    received byte, qualified by rx_valid
//   rx_valid   one-cycle pulse per received byte
//   status_in  eight read-only status bytes at addresses 8..15
//   tx_byte    registered byte for the next SPI shift-out
//   ctrl_regs  eight read/write control bytes at addresses 0..7
//   wr_strobe  one-cycle pulse per accepted control-register write
//   wr_addr    index of the control register just written
//   busy       high whenever a frame is in progress
//   err        sticky protocol error flag
module spi_reg_ctrl #(
    parameter int unsigned TIMEOUT   = 16000,
    parameter logic [7:0]  IDLE_BYTE = 8'h81
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic [63:0] status_in,
    output logic [7:0]  tx_byte,
    output logic [63:0] ctrl_regs,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic        busy,
    output logic        err
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [7:0] CmdClearErr = 8'h40;

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDiscard} state_e;

    state_e          state_q, state_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      tx_q, tx_d;
    logic [63:0]     ctrl_q, ctrl_d;
    logic            strobe_q, strobe_d;
    logic [2:0]      wr_addr_q, wr_addr_d;
    logic            err_q, err_d;
    logic            busy_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      addr_inc;

    // Unified 16-byte map: 0..7 control, 8..15 status.
    function automatic logic [7:0] byte_at(input logic [3:0] a, input logic [63:0] cr,
                                           input logic [63:0] st);
        if (a[3]) begin
            return st[{a[2:0], 3'b000} +: 8];
        end
        return cr[{a[2:0], 3'b000} +: 8];
    endfunction

    assign addr_inc = addr_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        ctrl_d    = ctrl_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        err_d     = err_q;
        cnt_d     = (state_q == StIdle || rx_valid) ? '0 : cnt_q + CntW'(1);

        if (frame_rst) begin
            // Abort wins over a coincident byte; registers and err survive.
            state_d = StIdle;
            tx_d    = IDLE_BYTE;
            cnt_d   = '0;
        end else if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    addr_d = rx_byte[3:0];
                    if (rx_byte == CmdClearErr) begin
                        err_d   = 1'b0;
                        state_d = StDiscard;
                    end else if (rx_byte[6:4] != 3'b000) begin
                        err_d   = 1'b1;
                        state_d = StDiscard;
                    end else if (rx_byte[7]) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                        tx_d    = byte_at(rx_byte[3:0], ctrl_q, status_in);
                    end
                end
                StWrite: begin
                    addr_d = addr_inc;
                    if (!addr_q[3]) begin
                        ctrl_d[{addr_q[2:0], 3'b000} +: 8] = rx_byte;
                        strobe_d  = 1'b1;
                        wr_addr_d = addr_q[2:0];
                    end else begin
                        // Status space is read-only: drop data and flag it.
                        err_d = 1'b1;
                    end
                end
                StRead: begin
                    addr_d = addr_inc;
                    tx_d   = byte_at(addr_inc, ctrl_q, status_in);
                end
                StDiscard: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end else if (state_q != StIdle && cnt_q == CntLast) begin
            // Inactivity timeout: silent abandon, err untouched.
            state_d = StIdle;
            tx_d    = IDLE_BYTE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= 4'd0;
            tx_q      <= IDLE_BYTE;
            ctrl_q    <= 64'd0;
            strobe_q  <= 1'b0;
            wr_addr_q <= 3'd0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            ctrl_q    <= ctrl_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            err_q     <= err_d;
            busy_q    <= (state_d != StIdle);
            cnt_q     <= cnt_d;
        end
    end

    assign tx_byte   = tx_q;
    assign ctrl_regs = ctrl_q;
    assign wr_strobe = strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    localparam int unsigned TOUT = 20;
    localparam logic [7:0]  IDLE = 8'h81;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_rst = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [63:0] status_in = 64'h0;
    logic [7:0]  tx_byte;
    logic [63:0] ctrl_regs;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    spi_reg_ctrl #(.TIMEOUT(TOUT), .IDLE_BYTE(IDLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_rst (frame_rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .status_in (status_in),
        .tx_byte   (tx_byte),
        .ctrl_regs (ctrl_regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame modes as plain integers: 0 no frame, 1 writing, 2 reading, 3 ignoring.
    int         m_mode;
    int         m_addr;
    int         m_quiet;
    logic [7:0] m_ctrl [8];
    logic [7:0] m_tx;
    bit         m_err;
    bit         m_strobe;
    int         m_wr_addr;

    function automatic logic [7:0] map_byte(input int a);
        if (a >= 8) return status_in[(a - 8) * 8 +: 8];
        return m_ctrl[a];
    endfunction

    function automatic logic [63:0] m_ctrl_flat();
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k * 8 +: 8] = m_ctrl[k];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode    <= 0;
            m_addr    <= 0;
            m_quiet   <= 0;
            m_tx      <= IDLE;
            m_err     <= 1'b0;
            m_strobe  <= 1'b0;
            m_wr_addr <= 0;
            for (int k = 0; k < 8; k++) m_ctrl[k] <= 8'h00;
        end else begin
            m_strobe <= 1'b0;
            if (frame_rst) begin
                m_mode  <= 0;
                m_tx    <= IDLE;
                m_quiet <= 0;
            end else if (rx_valid) begin
                m_quiet <= 0;
                if (m_mode == 0) begin
                    m_addr <= int'(rx_byte[3:0]);
                    if (rx_byte == 8'h40) begin
                        m_err  <= 1'b0;
                        m_mode <= 3;
                    end else if (rx_byte[6:4] != 3'b000) begin
                        m_err  <= 1'b1;
                        m_mode <= 3;
                    end else if (rx_byte[7]) begin
                        m_mode <= 1;
                    end else begin
                        m_mode <= 2;
                        m_tx   <= map_byte(int'(rx_byte[3:0]));
                    end
                end else if (m_mode == 1) begin
                    if (m_addr < 8) begin
                        m_ctrl[m_addr] <= rx_byte;
                        m_strobe       <= 1'b1;
                        m_wr_addr      <= m_addr;
                    end else begin
                        m_err <= 1'b1;
                    end
                    m_addr <= (m_addr + 1) % 16;
                end else if (m_mode == 2) begin
                    m_addr <= (m_addr + 1) % 16;
                    m_tx   <= map_byte((m_addr + 1) % 16);
                end
            end else if (m_mode != 0) begin
                if (m_quiet + 1 == int'(TOUT)) begin
                    m_mode  <= 0;
                    m_tx    <= IDLE;
                    m_quiet <= 0;
                end else begin
                    m_quiet <= m_quiet + 1;
                end
            end
        end
    end

    // One compare per cycle, away from the active edge.
    always @(negedge clk) begin
        if (checking && !rst) begin
            chk("tx_byte", {56'd0, tx_byte}, {56'd0, m_tx});
            chk("ctrl_regs", ctrl_regs, m_ctrl_flat());
            chk("wr_strobe", {63'd0, wr_strobe}, {63'd0, m_strobe});
            if (m_strobe) chk("wr_addr", {61'd0, wr_addr}, 64'(m_wr_addr));
            chk("busy", {63'd0, busy}, {63'd0, m_mode != 0});
            chk("err", {63'd0, err}, {63'd0, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frst();
        frame_rst = 1'b1;
        @(negedge clk);
        frame_rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        idle(2);
        chk("reset_tx", {56'd0, tx_byte}, 64'h81);
        chk("reset_ctrl", ctrl_regs, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        checking = 1'b1;
        idle(1);

        // Write burst at address 2.
        send(8'h82);
        send(8'hAA);
        chk("wb_strobe1", {63'd0, wr_strobe}, 64'd1);
        chk("wb_addr1", {61'd0, wr_addr}, 64'd2);
        send(8'h55);
        chk("wb_addr2", {61'd0, wr_addr}, 64'd3);
        idle(1);
        chk("wb_regs", ctrl_regs[31:16], 64'h55AA);
        chk("wb_nostrobe", {63'd0, wr_strobe}, 64'd0);
        chk("wb_busy", {63'd0, busy}, 64'd1);
        frst();
        chk("wb_busy_after_frst", {63'd0, busy}, 64'd0);

        // Read with wrap from 15 to 0.
        send(8'h80);
        send(8'h11);
        send(8'h22);
        frst();
        status_in[63:56] = 8'hC3;
        send(8'h0F);
        chk("rd_cmd", {56'd0, tx_byte}, 64'hC3);
        status_in[63:56] = 8'h5A; // not tracked until the next load
        idle(2);
        chk("rd_hold", {56'd0, tx_byte}, 64'hC3);
        send(8'hFF);
        chk("rd_wrap", {56'd0, tx_byte}, 64'h11);
        send(8'h00);
        chk("rd_next", {56'd0, tx_byte}, 64'h22);
        frst();
        chk("rd_idle_tx", {56'd0, tx_byte}, 64'h81);

        // Illegal command, ignored bytes, then clear.
        send(8'h10);
        chk("ill_err", {63'd0, err}, 64'd1);
        send(8'h82);
        send(8'hFF);
        chk("ill_ignored", ctrl_regs[23:16], 64'hAA);
        frst();
        send(8'h40);
        chk("clr_err", {63'd0, err}, 64'd0);
        chk("clr_busy", {63'd0, busy}, 64'd1);
        frst();

        // Write running into the read-only space.
        send(8'h87);
        send(8'h01);
        chk("ro_byte7", ctrl_regs[63:56], 64'h01);
        chk("ro_addr", {61'd0, wr_addr}, 64'd7);
        send(8'h02);
        chk("ro_nostrobe", {63'd0, wr_strobe}, 64'd0);
        chk("ro_err", {63'd0, err}, 64'd1);
        frst();
        send(8'h40);
        frst();

        // Timeout after 20 quiet cycles.
        send(8'h81);
        idle(19);
        chk("to_busy19", {63'd0, busy}, 64'd1);
        idle(1);
        chk("to_busy20", {63'd0, busy}, 64'd0);
        chk("to_tx", {56'd0, tx_byte}, 64'h81);
        chk("to_err", {63'd0, err}, 64'd0);

        // Byte arriving on the expiry cycle is processed.
        send(8'h81);
        idle(19);
        send(8'h33);
        chk("to_race_reg", ctrl_regs[15:8], 64'h33);
        chk("to_race_busy", {63'd0, busy}, 64'd1);
        frst();

        // frame_rst together with rx_valid in a write frame.
        send(8'h83);
        frame_rst = 1'b1;
        send(8'hEE);
        frame_rst = 1'b0;
        chk("col_reg", ctrl_regs[31:24], 64'h55);
        chk("col_strobe", {63'd0, wr_strobe}, 64'd0);
        idle(1);

        // Async reset mid-read, err set beforehand.
        send(8'h10);
        frst();
        send(8'h01);
        send(8'h00);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", {56'd0, tx_byte}, 64'h81);
        chk("arst_ctrl", ctrl_regs, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_err", {63'd0, err}, 64'd0);
        chk("arst_strobe", {63'd0, wr_strobe}, 64'd0);
        chk("arst_wr_addr", {61'd0, wr_addr}, 64'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        send(8'h84);
        send(8'h9C);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command sequencer and register file behind the SPI byte receiver on the TinyFPGA BX design. It consumes received bytes (`rx_byte`/`rx_valid`), decodes a one-byte command header, then streams writes into eight control registers or streams reads from control and status registers. It also supplies the byte the SPI slave shifts out next (`tx_byte`). A frame ends on an explicit frame reset or an inactivity timeout.

## Interface
- `TIMEOUT`, default 16000: idle cycles inside a frame before it is abandoned (1 ms at 16 MHz).
- `IDLE_BYTE`, default 8'h81: `tx_byte` value outside read frames.

- `clk` in 1: 16 MHz system clock.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `frame_rst` in 1: synchronous, active-high; aborts the current frame and returns to IDLE.
- `rx_byte` in 8: received byte; valid only when `rx_valid` is high.
- `rx_valid` in 1: single-cycle pulse per received byte.
- `status_in` in 64: eight read-only status bytes; byte k is `status_in[8k+7:8k]` and sits at address 8+k.
- `tx_byte` out 8: byte to shift out on the next SPI byte; registered.
- `ctrl_regs` out 64: eight control bytes; byte k is `ctrl_regs[8k+7:8k]` and sits at address k.
- `wr_strobe` out 1: one-cycle pulse when a control register is written.
- `wr_addr` out 3: index of the register written; valid with `wr_strobe`.
- `busy` out 1: high whenever state is not IDLE.
- `err` out 1: sticky protocol error flag.

## Operation
- The address space is 4 bits wide. Addresses 0–7 are the RW `ctrl_regs`. Addresses 8–15 are the RO `status_in`.
- Command byte: bit7 is W (1) or R (0), bits6:4 must be 000, bits3:0 give the start address.
- Exactly 8'h40 is CLEAR_ERR: it clears `err` and moves to DISCARD.
- Any other command with bits6:4 ≠ 000 sets `err` and moves to DISCARD.
- States:
  - IDLE: on `rx_valid`, decode the command. W goes to WRITE. R goes to READ. Illegal or CLEAR_ERR goes to DISCARD. `addr` loads from bits3:0.
  - WRITE: each `rx_valid` writes `rx_byte` to `addr`, then increments `addr`.
    - If `addr` < 8: update `ctrl_regs`, pulse `wr_strobe`, set `wr_addr` = `addr[2:0]`.
    - If `addr` ≥ 8: drop the data, set `err`, no strobe.
  - READ: `tx_byte` holds the byte at `addr`. Each `rx_valid` increments `addr`, and `tx_byte` reloads from the new address. Received data is ignored.
  - DISCARD: ignore all bytes until `frame_rst` or timeout.
- Address increment wraps from 15 to 0 in both WRITE and READ.
- `tx_byte` is `IDLE_BYTE` in IDLE, WRITE and DISCARD.
- Timeout counter:
  - Clears on every `rx_valid` and whenever in IDLE.
  - Counts while not in IDLE.
  - When it reaches `TIMEOUT-1`, the next cycle forces IDLE. `err` is not set.
- `frame_rst` forces IDLE next cycle from any state. `ctrl_regs` and `err` are preserved.

## Timing
- Reset values:
  - state IDLE, `addr` 0, `tx_byte` = `IDLE_BYTE`.
  - `ctrl_regs` all 0.
  - `wr_strobe` 0, `wr_addr` 0, `busy` 0, `err` 0, timeout counter 0.
- All outputs are registered. Every response to `rx_valid` in cycle N appears in cycle N+1:
  - state change
  - `ctrl_regs` update and `wr_strobe`
  - `tx_byte` reload
- `status_in` is sampled into `tx_byte` at load time only. Later changes are not tracked until the next load.
- `frame_rst` together with `rx_valid` in the same cycle: `frame_rst` wins and the byte is dropped.
- Timeout expiry together with `rx_valid`: `rx_valid` wins, the byte is processed and the counter clears.
- Asserting `rst` mid-frame clears everything immediately, including `ctrl_regs`. The frame is lost.
- `wr_strobe` is high for exactly one cycle per accepted write byte. Back-to-back `rx_valid` (every cycle) must be handled without loss.

## Test plan
- Write burst: reset, then bytes 8'h82, 8'hAA, 8'h55.
  - `ctrl_regs` byte2 = AA, byte3 = 55.
  - `wr_strobe` pulses twice, with `wr_addr` 2 then 3.
  - `busy` stays 1 until `frame_rst`.
- Read with wrap: set `status_in` byte7 = 8'hC3 and `ctrl_regs` byte0 = 8'h11, then send 8'h0F and two filler bytes.
  - `tx_byte` reads C3 after the command, 11 after filler 1, and byte1 after filler 2.
- Illegal and clear:
  - Send 8'h10: `err` = 1, state DISCARD, subsequent bytes have no effect.
  - Then `frame_rst`, then 8'h40: `err` = 0.
- RO write: command 8'h87, then 8'h01, 8'h02.
  - byte7 is written with `wr_strobe`.
  - 8'h02 targets addr 8: dropped, `err` = 1, no strobe.
- Timeout (`TIMEOUT` = 20): send 8'h81, then idle 20 cycles.
  - `busy` falls on cycle 20 after the byte, `tx_byte` returns to 8'h81, `err` stays 0.
- Collisions:
  - `frame_rst` together with `rx_valid` in WRITE: no register change.
  - Async `rst` mid-READ: all outputs take their reset values within the same cycle.
